// File: rtl/debouncer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : debouncer_pkg
// Description : Shared state encoding and widths for the debouncer.
// Revision    : 1.0 - initial release
// ============================================================================
package debouncer_pkg;

    typedef enum logic [1:0] {
        S_LOW        = 2'd0,
        S_MAYBE_HIGH = 2'd1,
        S_HIGH       = 2'd2,
        S_MAYBE_LOW  = 2'd3
    } debounce_state_t;

    localparam int GLITCH_CNT_W = 8;

endpackage
`default_nettype wire

// File: rtl/synchronizer.sv
`default_nettype none
// ============================================================================
// Module      : synchronizer
// Description : Multi-flop synchronizer for a single asynchronous input bit.
// Revision    : 1.0 - initial release
// ============================================================================
module synchronizer #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] r_chain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], d};
        end
    end

    assign q = r_chain[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/debouncer.sv
`default_nettype none
// ============================================================================
// Module      : debouncer
// Description : Synchronizes a bouncy async input and filters short pulses.
//               Optional glitch counter enabled by DEBOUNCER_GLITCH_COUNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module debouncer
    import debouncer_pkg::*;
#(
    parameter int BOUNCE_TICKS = 10,
    parameter int SYNC_STAGES  = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_in,
    output logic debounced,
    output logic stable
`ifdef DEBOUNCER_GLITCH_COUNT_EN
    ,
    output logic [GLITCH_CNT_W-1:0] glitch_count
`endif
);

    localparam int CNT_W = $clog2(BOUNCE_TICKS + 1);
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(BOUNCE_TICKS - 1);

    logic             w_synced;
    debounce_state_t  r_state;
    debounce_state_t  w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             r_debounced;
    logic             r_stable;

    synchronizer #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (raw_in),
        .q   (w_synced)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_LOW;
            r_cnt       <= '0;
            r_debounced <= 1'b0;
            r_stable    <= 1'b1;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_debounced <= (w_state_next == S_HIGH) || (w_state_next == S_MAYBE_LOW);
            r_stable    <= (w_state_next == S_LOW)  || (w_state_next == S_HIGH);
        end
    end

    // An opposite sample takes priority over the commit check in a MAYBE state.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            S_LOW: begin
                if (w_synced) begin
                    w_state_next = S_MAYBE_HIGH;
                    w_cnt_next   = '0;
                end
            end
            S_MAYBE_HIGH: begin
                if (!w_synced) begin
                    w_state_next = S_LOW;
                    w_cnt_next   = '0;
                end else if (r_cnt == c_cnt_last) begin
                    w_state_next = S_HIGH;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            S_HIGH: begin
                if (!w_synced) begin
                    w_state_next = S_MAYBE_LOW;
                    w_cnt_next   = '0;
                end
            end
            S_MAYBE_LOW: begin
                if (w_synced) begin
                    w_state_next = S_HIGH;
                    w_cnt_next   = '0;
                end else if (r_cnt == c_cnt_last) begin
                    w_state_next = S_LOW;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_next = S_LOW;
                w_cnt_next   = '0;
            end
        endcase
    end

    assign debounced = r_debounced;
    assign stable    = r_stable;

`ifdef DEBOUNCER_GLITCH_COUNT_EN
    logic                    w_abort;
    logic [GLITCH_CNT_W-1:0] r_glitch_cnt;

    assign w_abort = ((r_state == S_MAYBE_HIGH) && !w_synced) ||
                     ((r_state == S_MAYBE_LOW)  &&  w_synced);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_glitch_cnt <= '0;
        end else if (w_abort && (r_glitch_cnt != '1)) begin
            r_glitch_cnt <= r_glitch_cnt + GLITCH_CNT_W'(1);
        end
    end

    assign glitch_count = r_glitch_cnt;
`endif

endmodule
`default_nettype wire
